// File: rtl/spi_pkg.sv
// Shared types and SPI pin idle levels for the spi_master_lite slice.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    DONE
  } spi_state_e;

  localparam logic SCK_IDLE  = 1'b0;
  localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period tick generator: counts 0..div while enabled and ticks on the
// last count, so each tick spaces div+1 enabled clocks.
module spi_clkdiv #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_lite.sv
// Single-frame SPI mode-0 initiator, MSB-first, with a valid/ready command
// port and a one-cycle response pulse.
module spi_master_lite #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned SS_W   = 8,
  parameter int unsigned LEN_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DIV_W-1:0]  req_div,
  input  logic [SS_W-1:0]   req_ss,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              sck,
  output logic [SS_W-1:0]   ss,
  output logic              mosi,
  input  logic              miso
);

  import spi_pkg::*;

  spi_state_e        state_q, state_d;
  logic              sck_q, sck_d;
  logic [SS_W-1:0]   ss_q, ss_d;
  logic              mosi_q, mosi_d;
  logic [LEN_W-1:0]  bits_q, bits_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              accept;
  logic              div_load;
  logic              div_en;
  logic              tick;
  logic [LEN_W-1:0]  len_sel;
  logic [DATA_W-1:0] tx_aligned;

  assign accept    = req_valid && (state_q == IDLE);
  assign len_sel   = ((req_len == '0) || (req_len > LEN_W'(DATA_W))) ? LEN_W'(DATA_W) : req_len;
  // Left-align the frame so the next bit to send is always the top bit.
  assign tx_aligned = req_data << (LEN_W'(DATA_W) - len_sel);
  assign div_load  = accept;
  assign div_en    = (state_q != IDLE) && (state_q != DONE);

  spi_clkdiv #(
    .DIV_W(DIV_W)
  ) u_clkdiv (
    .clock (clock),
    .resetn(resetn),
    .load  (div_load),
    .en    (div_en),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    sck_d       = sck_q;
    ss_d        = ss_q;
    mosi_d      = mosi_q;
    bits_d      = bits_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    div_d       = div_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          div_d   = req_div;
          bits_d  = len_sel;
          tx_d    = tx_aligned;
          rx_d    = '0;
          ss_d    = ~req_ss;
          sck_d   = SCK_IDLE;
          mosi_d  = tx_aligned[DATA_W-1];
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SCK_HI;
          sck_d   = 1'b1;
        end
      end
      SCK_HI: begin
        // Falling edge: sample miso as seen before the edge, then advance mosi.
        if (tick) begin
          state_d = SCK_LO;
          sck_d   = 1'b0;
          rx_d    = {rx_q[DATA_W-2:0], miso};
          tx_d    = tx_q << 1;
          bits_d  = bits_q - 1'b1;
          if (bits_d != '0) begin
            mosi_d = tx_d[DATA_W-1];
          end
        end
      end
      SCK_LO: begin
        if (tick) begin
          if (bits_q != '0) begin
            state_d = SCK_HI;
            sck_d   = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = DONE;
          ss_d    = '1;
          mosi_d  = MOSI_IDLE;
        end
      end
      DONE: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = rx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sck_q       <= SCK_IDLE;
      ss_q        <= '1;
      mosi_q      <= MOSI_IDLE;
      bits_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      div_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
      bits_q      <= bits_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      div_q       <= div_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sck       = sck_q;
  assign ss        = ss_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_lite.sv
// Randomized frame-level bench for spi_master_lite with a behavioural SPI
// pin monitor and a word-level response model.
module tb_spi_master_lite;

  logic        clock;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_data;
  logic [4:0]  req_len;
  logic [7:0]  req_div;
  logic [7:0]  req_ss;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic        sck;
  logic [7:0]  ss;
  logic        mosi;
  logic        miso;

  int unsigned miso_mode;
  int unsigned cyc;
  int unsigned n_vec;
  int unsigned n_err;

  // Pin monitor state
  int unsigned rises;
  bit          mosi_seen[$];
  int unsigned bad_ss;
  int unsigned bad_w;
  int unsigned exp_h;
  logic [7:0]  exp_ss;
  logic        prev_sck;
  int unsigned last_edge;
  bit          have_fall;
  int unsigned ss_run;
  int unsigned last_gap;

  spi_master_lite #(
    .DATA_W(16),
    .DIV_W (8),
    .SS_W  (8)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_len  (req_len),
    .req_div  (req_div),
    .req_ss   (req_ss),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .sck      (sck),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave-side responder: loopback, constant 0, constant 1, inverted loopback.
  always_comb begin
    case (miso_mode)
      1:       miso = 1'b0;
      2:       miso = 1'b1;
      3:       miso = ~mosi;
      default: miso = mosi;
    endcase
  end

  always @(negedge clock) begin
    if (sck && !prev_sck) begin
      rises++;
      mosi_seen.push_back(mosi);
      if (ss !== exp_ss) bad_ss++;
      if (have_fall && (cyc - last_edge != exp_h)) bad_w++;
      last_edge = cyc;
    end
    if (!sck && prev_sck) begin
      if (cyc - last_edge != exp_h) bad_w++;
      last_edge = cyc;
      have_fall = 1'b1;
    end
    prev_sck = sck;
    if (ss == 8'hFF) begin
      ss_run++;
    end else begin
      if (ss_run > 0) last_gap = ss_run;
      ss_run = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int unsigned eff_len(input logic [4:0] len);
    return ((len == 0) || (len > 16)) ? 16 : int'(len);
  endfunction

  function automatic logic [15:0] len_mask(input int unsigned l);
    logic [16:0] m;
    m = (17'd1 << l) - 17'd1;
    return m[15:0];
  endfunction

  function automatic logic [15:0] model_rsp(input logic [15:0] d, input int unsigned l,
                                            input int unsigned mode);
    case (mode)
      1:       return 16'h0000;
      2:       return len_mask(l);
      3:       return ~d & len_mask(l);
      default: return d & len_mask(l);
    endcase
  endfunction

  task automatic clear_mon(input logic [7:0] div, input logic [7:0] s);
    rises     = 0;
    mosi_seen.delete();
    bad_ss    = 0;
    bad_w     = 0;
    have_fall = 1'b0;
    exp_h     = int'(div) + 1;
    exp_ss    = ~s;
  endtask

  task automatic send(input logic [15:0] d, input logic [4:0] len, input logic [7:0] div,
                      input logic [7:0] s, input bit hold, output int unsigned acc);
    int unsigned n;
    n = 0;
    @(negedge clock);
    req_data  = d;
    req_len   = len;
    req_div   = div;
    req_ss    = s;
    req_valid = 1'b1;
    while (!req_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    check_eq("accept_wait", 32'(n < 500), 32'd1);
    @(negedge clock);
    acc       = cyc;
    req_valid = hold;
    clear_mon(div, s);
  endtask

  task automatic wait_rsp(output int unsigned rc, output logic [15:0] got);
    int unsigned n;
    n = 0;
    while (!rsp_valid && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check_eq("rsp_wait", 32'(n < 5000), 32'd1);
    rc  = cyc;
    got = rsp_data;
    @(negedge clock);
    check_eq("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  function automatic logic [15:0] pack_mosi();
    logic [15:0] w;
    w = '0;
    foreach (mosi_seen[i]) w = {w[14:0], mosi_seen[i]};
    return w;
  endfunction

  task automatic check_frame(input string tag, input logic [15:0] d, input logic [4:0] len,
                             input logic [7:0] div, input int unsigned acc,
                             input int unsigned rc, input logic [15:0] got);
    int unsigned l;
    l = eff_len(len);
    check_eq({tag, "_rsp"}, 32'(got), 32'(model_rsp(d, l, miso_mode)));
    check_eq({tag, "_lat"}, rc - acc, (2 * l + 2) * (int'(div) + 1) + 1);
    check_eq({tag, "_rises"}, rises, l);
    check_eq({tag, "_mosi"}, 32'(pack_mosi()), 32'(d & len_mask(l)));
    check_eq({tag, "_ss"}, bad_ss, 0);
    check_eq({tag, "_width"}, bad_w, 0);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] d, input logic [4:0] len,
                           input logic [7:0] div, input logic [7:0] s, input int unsigned mode);
    int unsigned acc, rc;
    logic [15:0] got;
    miso_mode = mode;
    send(d, len, div, s, 1'b0, acc);
    wait_rsp(rc, got);
    check_frame(tag, d, len, div, acc, rc, got);
    check_eq({tag, "_idle"}, {ss, sck, mosi, req_ready, busy}, {8'hFF, 1'b0, 1'b1, 1'b1, 1'b0});
  endtask

  initial begin
    int unsigned acc, rc, acc2, rc2, n;
    logic [15:0] got, got2;
    logic [15:0] rd;
    logic [4:0]  rl;
    logic [7:0]  rv, rs;
    bit          saw_rsp;

    n_vec = 0; n_err = 0;
    miso_mode = 0;
    resetn = 1'b0; req_valid = 1'b0; req_data = '0; req_len = '0; req_div = '0; req_ss = '0;
    prev_sck = 1'b0; last_edge = 0; ss_run = 0; last_gap = 0;
    clear_mon(8'd0, 8'd0);

    // Reset values and quiet idle
    repeat (3) @(negedge clock);
    check_eq("rst_pins", {ss, sck, mosi}, {8'hFF, 1'b0, 1'b1});
    check_eq("rst_flags", {req_ready, busy, rsp_valid}, 3'b100);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'h0);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    check_eq("idle_quiet", {busy, rises[3:0], ss}, {1'b0, 4'd0, 8'hFF});

    // Directed frames
    run_frame("lb8", 16'h00A5, 5'd8, 8'd0, 8'h01, 0);
    run_frame("lb16", 16'h1234, 5'd16, 8'd3, 8'h01, 0);
    run_frame("len0", 16'h0000, 5'd0, 8'd1, 8'h02, 2);

    // Back-to-back with req_valid held
    miso_mode = 0;
    send(16'h003C, 5'd8, 8'd0, 8'h01, 1'b1, acc);
    @(negedge clock);
    req_data = 16'h00C3;
    wait_rsp(rc, got);
    check_frame("b2b1", 16'h003C, 5'd8, 8'd0, acc, rc, got);
    acc2 = cyc;
    check_eq("b2b_accept", {busy, req_ready}, 2'b10);
    req_valid = 1'b0;
    clear_mon(8'd0, 8'h01);
    wait_rsp(rc2, got2);
    check_frame("b2b2", 16'h00C3, 5'd8, 8'd0, acc2, rc2, got2);
    check_eq("b2b_gap", last_gap, 2);

    // Reset mid-frame after the 5th rising edge
    miso_mode = 0;
    send(16'hBEEF, 5'd16, 8'd2, 8'h0F, 1'b0, acc);
    n = 0;
    while (rises < 5 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check_eq("mid_wait", 32'(n < 2000), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("mid_pins", {ss, sck, mosi}, {8'hFF, 1'b0, 1'b1});
    check_eq("mid_flags", {req_ready, busy, rsp_valid}, 3'b100);
    saw_rsp = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    resetn = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check_eq("mid_no_rsp", 32'(saw_rsp), 32'd0);
    run_frame("post_rst", 16'h005A, 5'd8, 8'd1, 8'h01, 0);

    // Randomized frames
    for (int unsigned i = 0; i < 14; i++) begin
      rd = 16'($urandom);
      rl = 5'($urandom_range(0, 16));
      rv = 8'($urandom_range(0, 3));
      rs = 8'($urandom_range(1, 255));
      run_frame("rnd", rd, rl, rv, rs, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_lite.md
Name: spi_master_lite

Overview:
- Single-frame SPI initiator (mode 0, MSB-first) driving the SPI-slave peripherals under perip/, such as the bit-reverse responder.
- Takes a command through a valid/ready request port and generates sck, active-low ss and mosi from a programmable divider.
- Samples miso and returns the received word with a one-cycle rsp_valid pulse.
- Sits between a bus-side register wrapper (not part of this block) and the SPI pins.

Parameters:
DATA_W, 16, maximum frame length in bits; width of request and response data.
DIV_W, 8, width of clock-divider field.
SS_W, 8, number of slave-select lines.
LEN_W, $clog2(DATA_W)+1, width of length field (derived; do not override).

Ports:
clock  in  1  system clock; all logic on posedge.
resetn  in  1  asynchronous active-low reset.
req_valid  in  1  command valid.
req_ready  out  1  block idle and able to accept a command.
req_data  in  DATA_W  transmit word; bits [len-1:0] are sent.
req_len  in  LEN_W  frame length in bits; 0 means DATA_W.
req_div  in  DIV_W  half-period of sck, in clocks, minus 1.
req_ss  in  SS_W  one-hot or multi-hot select; bit i=1 asserts ss[i].
rsp_valid  out  1  one-cycle pulse: rsp_data valid.
rsp_data  out  DATA_W  received word, LSB-aligned; upper bits zero.
busy  out  1  high from accept through the DONE cycle.
sck  out  1  SPI clock, idle low.
ss  out  SS_W  active-low selects.
mosi  out  1  serial data out.
miso  in  1  serial data in.

Behaviour:
- Reset (async, resetn=0):
  - State IDLE; sck=0, ss all ones, mosi=1.
  - rsp_valid=0, rsp_data=0, busy=0, req_ready=1.
  - All counters 0.
- Handshake:
  - A command is accepted on a posedge with req_valid&&req_ready.
  - At acceptance, req_data, req_len (0 -> DATA_W), req_div and req_ss are latched.
  - req_ready=1 only in IDLE.
- Half-period H = req_div+1 clocks (div=0 -> sck = clock/2).
- States:
  - IDLE: wait for accept -> SETUP.
  - SETUP: ss = ~latched_ss, sck=0, mosi = data[len-1]; hold H clocks -> SCK_HI.
  - SCK_HI: sck=1 for H clocks; the slave samples mosi and updates miso on this rising edge. After H clocks -> SCK_LO.
  - SCK_LO (entered with sck falling): on the falling-edge cycle the master samples miso into the LSB of the rx shift register and advances mosi to the next lower bit, in the same clock.
    - The miso sample uses the pre-edge registered value, so loopback mosi->miso returns req_data exactly.
    - Remaining bits decremented; if bits remain, hold H clocks -> SCK_HI, else -> HOLD.
  - HOLD: sck=0, ss still asserted, H clocks -> DONE.
  - DONE: ss all ones, mosi=1, rsp_valid=1 for exactly one cycle, rsp_data updated this cycle -> IDLE.
- Latency: exactly (2*len+2)*H+1 clocks from the accept edge to rsp_valid high.
- Frame shape:
  - sck has exactly len rising edges per frame; no glitch on ss or sck.
  - Minimum ss-high gap between frames is 2 clocks (the DONE and accept cycles).
- rsp_data holds its value until the next DONE; it is not cleared at accept.
- req_valid during busy is ignored (no queueing). A command held valid is accepted on the first IDLE cycle.
- resetn asserted mid-frame: outputs go to reset values immediately (asynchronously); no rsp_valid; the partial frame is discarded.
- Width rules:
  - Bit counter is LEN_W wide.
  - Divider counter is DIV_W wide and compares against the latched div; no wrap beyond div.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, SETUP, SCK_HI, SCK_LO, HOLD, DONE);
  - SPI idle constants (SCK_IDLE=0, MOSI_IDLE=1).
- One sub-module, spi_clkdiv: half-period tick generator (load, count to div, emit tick), reusable by a future slave-side clock checker.
- Shift datapath stays in the top module.

Test Plan:
1. Reset: hold resetn=0 -> ss=0xFF, sck=0, mosi=1, req_ready=1, busy=0, rsp_valid=0; release, no activity without req_valid.
2. Loopback (miso=mosi), div=0, len=8, data=0x00A5, ss=0x01:
   - ss=0xFE during the frame, 8 sck rising edges, sck period 2 clocks.
   - rsp_valid exactly 19 clocks after accept; rsp_data=0x00A5.
3. Loopback, div=3, len=16, data=0x1234:
   - sck high 4 and low 4 clocks.
   - rsp_valid at 137 clocks after accept; rsp_data=0x1234.
4. len=0, miso tied 1, data=0x0000 -> 16 sck edges, mosi constant 0, rsp_data=0xFFFF.
5. Back-to-back: req_valid held high with two commands (0x3C, then 0xC3; len=8, loopback):
   - second accept on the cycle after the first rsp_valid;
   - ss high for at least 2 clocks between frames;
   - responses 0x003C then 0x00C3.
6. Reset mid-frame: assert resetn=0 after the 5th sck rising edge:
   - sck=0 and ss=0xFF immediately, no rsp_valid;
   - after release, a new 0x5A loopback frame returns 0x005A.
